ctrl_decode_fsm: RTL and testbench

- Sequencing control unit that drives the 8-bit ALU and register file.
- Accepts 32-bit instructions over a valid/ready handshake and decodes opcode [31:24] into registered ALU and datapath controls.
- Sequences multi-cycle data-memory accesses against MEM_BUSYWAIT.
- Consumes the ALU ZERO flag to resolve BEQ/BNE.

---
 rtl/ctrl_pkg.sv | 65 ++++++
 rtl/ctrl_decode_fsm_if.sv | 32 +++
 rtl/ctrl_decode_fsm_op_decode.sv | 97 +++++++++
 rtl/ctrl_decode_fsm.sv | 142 ++++++++++++++
 tb/tb_ctrl_decode_fsm.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ctrl_decode_fsm sequencing control unit:
// opcode map, ALU and shift encodings, FSM states and the decoded control bundle.
package ctrl_pkg;

  localparam int OPW    = 8;
  localparam int ALUOPW = 3;

  localparam logic [OPW-1:0] OP_LOADI = 8'h00;
  localparam logic [OPW-1:0] OP_MOV   = 8'h01;
  localparam logic [OPW-1:0] OP_ADD   = 8'h02;
  localparam logic [OPW-1:0] OP_SUB   = 8'h03;
  localparam logic [OPW-1:0] OP_AND   = 8'h04;
  localparam logic [OPW-1:0] OP_OR    = 8'h05;
  localparam logic [OPW-1:0] OP_J     = 8'h06;
  localparam logic [OPW-1:0] OP_BEQ   = 8'h07;
  localparam logic [OPW-1:0] OP_MUL   = 8'h08;
  localparam logic [OPW-1:0] OP_SLL   = 8'h09;
  localparam logic [OPW-1:0] OP_SRL   = 8'h0A;
  localparam logic [OPW-1:0] OP_SRA   = 8'h0B;
  localparam logic [OPW-1:0] OP_ROR   = 8'h0C;
  localparam logic [OPW-1:0] OP_BNE   = 8'h0D;
  localparam logic [OPW-1:0] OP_LWD   = 8'h0E;
  localparam logic [OPW-1:0] OP_LWI   = 8'h0F;
  localparam logic [OPW-1:0] OP_SWD   = 8'h10;
  localparam logic [OPW-1:0] OP_SWI   = 8'h11;

  typedef enum logic [ALUOPW-1:0] {
    ALU_FWD   = 3'b000,
    ALU_ADD   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_MUL   = 3'b100,
    ALU_SHIFT = 3'b101
  } aluop_t;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MEM  = 3'd2,
    ST_WB   = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  // Everything the EXEC cycle needs, captured on the accept edge.
  typedef struct packed {
    aluop_t aluop;
    logic   neg_sel;
    logic   imm_sel;
    shift_t shift_type;
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    logic   is_jump;
    logic   is_beq;
    logic   is_bne;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_fsm_if.sv
// Instruction handshake plus ALU/datapath control bundle of ctrl_decode_fsm.
// master = instruction source / datapath side, slave = the decoder itself.
interface ctrl_decode_fsm_if;
  import ctrl_pkg::*;

  logic [31:0]       INSTRUCTION;
  logic              INSTR_VALID;
  logic              INSTR_READY;
  logic              ZERO;
  logic              MEM_BUSYWAIT;
  logic [ALUOPW-1:0] ALUOP;
  logic              NEG_SEL;
  logic              IMM_SEL;
  logic [1:0]        SHIFT_TYPE;
  logic              REG_WRITE;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic              BRANCH_TAKEN;
  logic              ILLEGAL;

  modport master (
    output INSTRUCTION, INSTR_VALID, ZERO, MEM_BUSYWAIT,
    input  INSTR_READY, ALUOP, NEG_SEL, IMM_SEL, SHIFT_TYPE,
           REG_WRITE, MEM_READ, MEM_WRITE, BRANCH_TAKEN, ILLEGAL
  );

  modport slave (
    input  INSTRUCTION, INSTR_VALID, ZERO, MEM_BUSYWAIT,
    output INSTR_READY, ALUOP, NEG_SEL, IMM_SEL, SHIFT_TYPE,
           REG_WRITE, MEM_READ, MEM_WRITE, BRANCH_TAKEN, ILLEGAL
  );
endinterface

// File: rtl/ctrl_decode_fsm_op_decode.sv
// Combinational opcode decoder: opcode -> control bundle plus is_mem/is_load/illegal.
// Illegal opcodes produce an all-zero bundle, which executes as a NOP.
module op_decode
  import ctrl_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl,
  output logic           is_mem,
  output logic           is_load,
  output logic           illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    ctrl    = '0;
    is_mem  = 1'b0;
    is_load = 1'b0;
    illegal = 1'b0;

    case (opcode)
      OP_LOADI: begin
        ctrl.aluop     = ALU_FWD;
        ctrl.imm_sel   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_MOV: begin
        ctrl.aluop     = ALU_FWD;
        ctrl.reg_write = 1'b1;
      end
      OP_ADD: begin
        ctrl.aluop     = ALU_ADD;
        ctrl.reg_write = 1'b1;
      end
      OP_SUB: begin
        ctrl.aluop     = ALU_ADD;
        ctrl.neg_sel   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_AND: begin
        ctrl.aluop     = ALU_AND;
        ctrl.reg_write = 1'b1;
      end
      OP_OR: begin
        ctrl.aluop     = ALU_OR;
        ctrl.reg_write = 1'b1;
      end
      OP_J: begin
        ctrl.is_jump = 1'b1;
      end
      OP_BEQ: begin
        ctrl.aluop   = ALU_ADD;
        ctrl.neg_sel = 1'b1;
        ctrl.is_beq  = 1'b1;
      end
      OP_MUL: begin
        ctrl.aluop     = ALU_MUL;
        ctrl.reg_write = 1'b1;
      end
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: begin
        ctrl.aluop      = ALU_SHIFT;
        ctrl.imm_sel    = 1'b1;
        // 09..0C map to 00..11: the low two opcode bits minus one.
        ctrl.shift_type = shift_t'(opcode[1:0] - 2'd1);
        ctrl.reg_write  = 1'b1;
      end
      OP_BNE: begin
        ctrl.aluop   = ALU_ADD;
        ctrl.neg_sel = 1'b1;
        ctrl.is_bne  = 1'b1;
      end
      OP_LWD: begin
        ctrl.mem_read = 1'b1;
        is_mem        = 1'b1;
        is_load       = 1'b1;
      end
      OP_LWI: begin
        ctrl.imm_sel  = 1'b1;
        ctrl.mem_read = 1'b1;
        is_mem        = 1'b1;
        is_load       = 1'b1;
      end
      OP_SWD: begin
        ctrl.mem_write = 1'b1;
        is_mem         = 1'b1;
      end
      OP_SWI: begin
        ctrl.imm_sel   = 1'b1;
        ctrl.mem_write = 1'b1;
        is_mem         = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_decode_fsm.sv
// Sequencing control unit: accepts instructions, registers decoded ALU/datapath
// controls and sequences memory accesses. Optional trap: CTRL_ILLEGAL_TRAP_EN.
module ctrl_decode_fsm
  import ctrl_pkg::*;
(
  input logic              CLK,
  input logic              RESET,
  ctrl_decode_fsm_if.slave bus
);

  state_t state;
  ctrl_t  dec;
  logic   dec_is_mem;
  logic   dec_is_load;
  logic   dec_illegal;
  logic   accept;

  // Registered per-instruction flags that steer the FSM and BRANCH_TAKEN.
  logic is_mem_q;
  logic is_load_q;
  logic is_jump_q;
  logic is_beq_q;
  logic is_bne_q;

  // Operand fields belong to the datapath; only the opcode is decoded here.
  logic unused_operands;
  assign unused_operands = ^bus.INSTRUCTION[31-OPW:0];

  op_decode u_op_decode (
    .opcode  (bus.INSTRUCTION[31 -: OPW]),
    .ctrl    (dec),
    .is_mem  (dec_is_mem),
    .is_load (dec_is_load),
    .illegal (dec_illegal)
  );

  assign bus.INSTR_READY = ~RESET &
                           ((state == ST_IDLE) || (state == ST_EXEC && !is_mem_q));
  assign accept          = bus.INSTR_VALID & bus.INSTR_READY;

  // ZERO comes straight from the ALU during EXEC, so the redirect stays combinational.
  assign bus.BRANCH_TAKEN = (state == ST_EXEC) &
                            (is_jump_q | (is_beq_q & bus.ZERO) | (is_bne_q & ~bus.ZERO));

`ifdef CTRL_ILLEGAL_TRAP_EN
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
  assign bus.ILLEGAL    = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: state and every registered output use non-blocking assignments only.
    if (RESET) begin
      state          <= ST_IDLE;
      bus.ALUOP      <= ALU_FWD;
      bus.NEG_SEL    <= 1'b0;
      bus.IMM_SEL    <= 1'b0;
      bus.SHIFT_TYPE <= SHIFT_SLL;
      bus.REG_WRITE  <= 1'b0;
      bus.MEM_READ   <= 1'b0;
      bus.MEM_WRITE  <= 1'b0;
      is_mem_q       <= 1'b0;
      is_load_q      <= 1'b0;
      is_jump_q      <= 1'b0;
      is_beq_q       <= 1'b0;
      is_bne_q       <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      bus.ILLEGAL    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_EXEC: begin
          if (state == ST_EXEC && is_mem_q) begin
            // Memory strobes were raised on the accept edge and stay up in MEM.
            state <= ST_MEM;
          end else if (accept) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (dec_illegal) begin
              state         <= ST_HALT;
              bus.ILLEGAL   <= 1'b1;
              bus.REG_WRITE <= 1'b0;
              bus.MEM_READ  <= 1'b0;
              bus.MEM_WRITE <= 1'b0;
              is_mem_q      <= 1'b0;
              is_load_q     <= 1'b0;
              is_jump_q     <= 1'b0;
              is_beq_q      <= 1'b0;
              is_bne_q      <= 1'b0;
            end else
`endif
            begin
              state          <= ST_EXEC;
              bus.ALUOP      <= dec.aluop;
              bus.NEG_SEL    <= dec.neg_sel;
              bus.IMM_SEL    <= dec.imm_sel;
              bus.SHIFT_TYPE <= dec.shift_type;
              bus.REG_WRITE  <= dec.reg_write;
              bus.MEM_READ   <= dec.mem_read;
              bus.MEM_WRITE  <= dec.mem_write;
              is_mem_q       <= dec_is_mem;
              is_load_q      <= dec_is_load;
              is_jump_q      <= dec.is_jump;
              is_beq_q       <= dec.is_beq;
              is_bne_q       <= dec.is_bne;
            end
          end else begin
            state         <= ST_IDLE;
            bus.REG_WRITE <= 1'b0;
            bus.MEM_READ  <= 1'b0;
            bus.MEM_WRITE <= 1'b0;
            is_mem_q      <= 1'b0;
            is_load_q     <= 1'b0;
            is_jump_q     <= 1'b0;
            is_beq_q      <= 1'b0;
            is_bne_q      <= 1'b0;
          end
        end

        ST_MEM: begin
          if (!bus.MEM_BUSYWAIT) begin
            bus.MEM_READ  <= 1'b0;
            bus.MEM_WRITE <= 1'b0;
            bus.REG_WRITE <= is_load_q;
            state         <= is_load_q ? ST_WB : ST_IDLE;
          end
        end

        ST_WB: begin
          bus.REG_WRITE <= 1'b0;
          state         <= ST_IDLE;
        end

        // Only RESET leaves HALT.
        ST_HALT: state <= ST_HALT;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_decode_fsm.sv
// Self-checking bench for ctrl_decode_fsm: directed scenarios followed by a
// randomized instruction stream checked against an opcode-table reference model.
module tb_ctrl_decode_fsm;
  import ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RESET;

  ctrl_decode_fsm_if bus ();

  ctrl_decode_fsm dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       legal;
    logic       load;
    logic       store;
    logic       neg;
    logic       imm;
    logic       writes;
    logic       aluop_known;
    logic       is_shift;
    logic [2:0] aluop;
    logic [1:0] sh;
  } model_t;

  // Reference decode built from the opcode table with plain integer ranges.
  function automatic model_t model(input logic [7:0] op);
    model_t m;
    int n;
    n = int'(op);
    m.legal       = (n <= 17);
    m.load        = (n == 14 || n == 15);
    m.store       = (n == 16 || n == 17);
    m.neg         = (n == 3 || n == 7 || n == 13);
    m.imm         = (n == 0 || (n >= 9 && n <= 12) || n == 15 || n == 17);
    m.writes      = (n <= 5) || (n >= 8 && n <= 12);
    m.is_shift    = (n >= 9 && n <= 12);
    m.sh          = m.is_shift ? 2'(n - 9) : 2'd0;
    m.aluop_known = (n <= 5) || (n >= 7 && n <= 13);
    case (n)
      2, 3, 7, 13:    m.aluop = 3'd1;
      4:              m.aluop = 3'd2;
      5:              m.aluop = 3'd3;
      8:              m.aluop = 3'd4;
      9, 10, 11, 12:  m.aluop = 3'd5;
      default:        m.aluop = 3'd0;
    endcase
    return m;
  endfunction

  function automatic logic branch_model(input logic [7:0] op, input logic z);
    return (op == 8'h06) || (op == 8'h07 && z) || (op == 8'h0D && !z);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_tick();
    bus.INSTR_VALID  = 1'b0;
    bus.INSTRUCTION  = $urandom;
    bus.MEM_BUSYWAIT = 1'($urandom_range(0, 1));
    tick();
    check("idle_reg_write", bus.REG_WRITE, 1'b0);
    check("idle_mem_read", bus.MEM_READ, 1'b0);
    check("idle_mem_write", bus.MEM_WRITE, 1'b0);
    check("idle_branch", bus.BRANCH_TAKEN, 1'b0);
    check("idle_ready", bus.INSTR_READY, 1'b1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    bus.INSTR_VALID  = 1'b0;
    bus.MEM_BUSYWAIT = 1'b0;
    bus.ZERO         = 1'b0;
    #1;
    check("rst_ready", bus.INSTR_READY, 1'b0);
    tick();
    check("rst_ready_held", bus.INSTR_READY, 1'b0);
    check("rst_reg_write", bus.REG_WRITE, 1'b0);
    check("rst_mem_read", bus.MEM_READ, 1'b0);
    check("rst_mem_write", bus.MEM_WRITE, 1'b0);
    check("rst_aluop", bus.ALUOP, 3'd0);
    check("rst_neg_sel", bus.NEG_SEL, 1'b0);
    check("rst_imm_sel", bus.IMM_SEL, 1'b0);
    check("rst_shift", bus.SHIFT_TYPE, 2'd0);
    check("rst_illegal", bus.ILLEGAL, 1'b0);
    check("rst_branch", bus.BRANCH_TAKEN, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    tick();
    check("post_rst_ready", bus.INSTR_READY, 1'b1);
  endtask

  // Issue one instruction from a ready state and follow it to completion.
  // busy = cycles MEM_BUSYWAIT stays high, counting from the EXEC cycle.
  // Non-memory ops return while still in EXEC so the next call is back-to-back.
  task automatic do_instr(input logic [7:0] op, input logic z, input int busy);
    model_t m;
    int     strobes;
    int     exp_strobes;
    logic   done;
    m = model(op);
    check("ready_pre", bus.INSTR_READY, 1'b1);
    bus.INSTRUCTION  = {op, 24'($urandom)};
    bus.INSTR_VALID  = 1'b1;
    bus.ZERO         = z;
    bus.MEM_BUSYWAIT = (busy > 0);
    tick();
    bus.INSTR_VALID = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (!m.legal) begin
      check("halt_illegal", bus.ILLEGAL, 1'b1);
      check("halt_ready", bus.INSTR_READY, 1'b0);
      check("halt_reg_write", bus.REG_WRITE, 1'b0);
      check("halt_mem_read", bus.MEM_READ, 1'b0);
      check("halt_mem_write", bus.MEM_WRITE, 1'b0);
      check("halt_branch", bus.BRANCH_TAKEN, 1'b0);
      return;
    end
`endif
    check("exec_illegal", bus.ILLEGAL, 1'b0);
    if (m.aluop_known) check("exec_aluop", bus.ALUOP, m.aluop);
    if (m.legal) begin
      check("exec_neg_sel", bus.NEG_SEL, m.neg);
      check("exec_imm_sel", bus.IMM_SEL, m.imm);
    end
    if (m.is_shift) check("exec_shift_type", bus.SHIFT_TYPE, m.sh);
    check("exec_reg_write", bus.REG_WRITE, m.writes);
    check("exec_mem_read", bus.MEM_READ, m.load);
    check("exec_mem_write", bus.MEM_WRITE, m.store);
    check("exec_branch", bus.BRANCH_TAKEN, branch_model(op, z));
    check("exec_ready", bus.INSTR_READY, !(m.load || m.store));

    if (m.load || m.store) begin
      strobes = (m.load ? bus.MEM_READ : bus.MEM_WRITE) ? 1 : 0;
      done    = 1'b0;
      for (int k = 1; k <= 16 && !done; k++) begin
        tick();
        bus.MEM_BUSYWAIT = (k < busy);
        if (m.load ? bus.MEM_READ : bus.MEM_WRITE) strobes++;
        check("mem_ready", bus.INSTR_READY, 1'b0);
        check("mem_reg_write", bus.REG_WRITE, 1'b0);
        done = !bus.MEM_BUSYWAIT;
      end
      tick();
      if (bus.MEM_READ || bus.MEM_WRITE) strobes++;
      exp_strobes = ((busy > 1) ? busy : 1) + 1;
      check("mem_strobe_cycles", strobes, exp_strobes);
      check("mem_done_read", bus.MEM_READ, 1'b0);
      check("mem_done_write", bus.MEM_WRITE, 1'b0);
      if (m.load) begin
        check("wb_reg_write", bus.REG_WRITE, 1'b1);
        check("wb_ready", bus.INSTR_READY, 1'b0);
        tick();
      end
      check("after_mem_reg_write", bus.REG_WRITE, 1'b0);
      check("after_mem_ready", bus.INSTR_READY, 1'b1);
      bus.MEM_BUSYWAIT = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] op;
    bus.INSTRUCTION  = '0;
    bus.INSTR_VALID  = 1'b0;
    bus.ZERO         = 1'b0;
    bus.MEM_BUSYWAIT = 1'b0;
    do_reset();

    // Back-to-back ADD then SUB.
    do_instr(OP_ADD, 1'b0, 0);
    do_instr(OP_SUB, 1'b0, 0);
    idle_tick();

    // Load with three busy cycles, then a zero-wait load.
    do_instr(OP_LWD, 1'b0, 3);
    do_instr(OP_LWI, 1'b1, 0);

    // Branch resolution against ZERO.
    do_instr(OP_BEQ, 1'b1, 0);
    bus.ZERO = 1'b0;
    #1;
    check("beq_zero_drop", bus.BRANCH_TAKEN, 1'b0);
    do_instr(OP_BEQ, 1'b0, 0);
    do_instr(OP_BNE, 1'b0, 0);
    do_instr(OP_BNE, 1'b1, 0);
    do_instr(OP_J, 1'b0, 0);
    bus.ZERO = 1'b1;
    #1;
    check("j_zero_high", bus.BRANCH_TAKEN, 1'b1);
    idle_tick();

    // Reset in the middle of a store's MEM phase.
    check("swd_ready", bus.INSTR_READY, 1'b1);
    bus.INSTRUCTION  = {OP_SWD, 24'($urandom)};
    bus.INSTR_VALID  = 1'b1;
    bus.MEM_BUSYWAIT = 1'b1;
    tick();
    bus.INSTR_VALID = 1'b0;
    check("swd_exec_write", bus.MEM_WRITE, 1'b1);
    tick();
    check("swd_mem_write", bus.MEM_WRITE, 1'b1);
    #2;
    RESET = 1'b1;
    #1;
    check("swd_rst_write", bus.MEM_WRITE, 1'b0);
    check("swd_rst_ready", bus.INSTR_READY, 1'b0);
    check("swd_rst_reg_write", bus.REG_WRITE, 1'b0);
    tick();
    check("swd_rst_hold_write", bus.MEM_WRITE, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    bus.MEM_BUSYWAIT = 1'b0;
    tick();
    check("swd_release_ready", bus.INSTR_READY, 1'b1);
    check("swd_release_reg_write", bus.REG_WRITE, 1'b0);
    do_instr(OP_MOV, 1'b0, 0);
    idle_tick();

    // Illegal opcode 0xFF.
    do_instr(8'hFF, 1'b0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    bus.INSTRUCTION = {OP_ADD, 24'h0};
    bus.INSTR_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("trap_sticky", bus.ILLEGAL, 1'b1);
      check("trap_ready", bus.INSTR_READY, 1'b0);
      check("trap_reg_write", bus.REG_WRITE, 1'b0);
    end
    do_reset();
    check("trap_cleared", bus.ILLEGAL, 1'b0);
`else
    do_instr(OP_OR, 1'b0, 0);
    idle_tick();
`endif

    // Randomized stream.
    for (int i = 0; i < 60; i++) begin
      op = 8'($urandom_range(0, 17));
`ifndef CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) op = 8'($urandom_range(18, 255));
`endif
      do_instr(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 1) idle_tick();
    end
    idle_tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
